// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - issues a nonce range across hash engines and reports hashes below target
module nonce_scheduler #(
  parameter int NUM_ENGINES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              nonce_base,
  input  logic [31:0]              nonce_count,
  input  logic [31:0]              target,
  output logic [NUM_ENGINES-1:0]   eng_start,
  output logic [32*NUM_ENGINES-1:0] eng_nonce,
  input  logic [NUM_ENGINES-1:0]   eng_done,
  input  logic [32*NUM_ENGINES-1:0] eng_hout,
  output logic                     found_valid,
  output logic [31:0]              found_nonce,
  output logic [31:0]              found_hash,
  input  logic                     found_ready,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              hit_count
);

  localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic { ST_IDLE, ST_RUN } state_e;
  typedef enum logic [1:0] { SL_FREE, SL_BUSY, SL_HIT } slot_e;

  state_e state_q, state_d;
  slot_e  slot_q [NUM_ENGINES];
  slot_e  slot_d [NUM_ENGINES];
  logic [31:0] snonce_q [NUM_ENGINES];
  logic [31:0] snonce_d [NUM_ENGINES];
  logic [31:0] shash_q [NUM_ENGINES];
  logic [31:0] shash_d [NUM_ENGINES];

  logic [31:0] next_nonce_q, next_nonce_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] target_q, target_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic        done_q, done_d;
  logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;

  logic          free_any, all_free, hit_any;
  logic [IW-1:0] disp_idx, hit_idx;
  logic          dispatch, accept, complete;

  // Priority scans give the lowest-index FREE slot and lowest-index HIT slot.
  always_comb begin
    free_any = 1'b0;
    all_free = 1'b1;
    hit_any  = 1'b0;
    disp_idx = '0;
    hit_idx  = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (slot_q[i] == SL_FREE) begin
        free_any = 1'b1;
        disp_idx = IW'(i);
      end else begin
        all_free = 1'b0;
      end
      if (slot_q[i] == SL_HIT) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && nonce_count != 32'd0) state_d = ST_RUN;
      ST_RUN:  if (complete) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Abort suppresses any dispatch in the cycle it is sampled.
  always_comb begin
    busy     = (state_q == ST_RUN);
    complete = busy && (remaining_q == 32'd0) && all_free;
    dispatch = busy && (remaining_q != 32'd0) && !abort && free_any;
    accept   = hit_any && found_ready;
  end

  always_comb begin
    next_nonce_d = next_nonce_q;
    remaining_d  = remaining_q;
    target_d     = target_q;
    hit_count_d  = hit_count_q;
    done_d       = 1'b0;
    eng_start_d  = '0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        next_nonce_d = nonce_base;
        remaining_d  = nonce_count;
        target_d     = target;
        hit_count_d  = 16'd0;
        done_d       = (nonce_count == 32'd0);
      end
    end else begin
      done_d = complete;
      if (abort) begin
        remaining_d = 32'd0;
      end else if (dispatch) begin
        remaining_d  = remaining_q - 32'd1;
        next_nonce_d = next_nonce_q + 32'd1;
        eng_start_d[disp_idx] = 1'b1;
      end
      if (accept && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
    end
  end

  // A done only lands on a BUSY slot and a dispatch only on a FREE one, so the cases never collide.
  always_comb begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      slot_d[i]   = slot_q[i];
      snonce_d[i] = snonce_q[i];
      shash_d[i]  = shash_q[i];
      if (slot_q[i] == SL_BUSY && eng_done[i]) begin
        shash_d[i] = eng_hout[32*i +: 32];
        slot_d[i]  = (eng_hout[32*i +: 32] < target_q) ? SL_HIT : SL_FREE;
      end else if (slot_q[i] == SL_HIT && accept && hit_idx == IW'(i)) begin
        slot_d[i] = SL_FREE;
      end else if (dispatch && disp_idx == IW'(i)) begin
        slot_d[i]   = SL_BUSY;
        snonce_d[i] = next_nonce_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_nonce_q <= '0;
      remaining_q  <= '0;
      target_q     <= '0;
      hit_count_q  <= '0;
      done_q       <= 1'b0;
      eng_start_q  <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_q[i]   <= SL_FREE;
        snonce_q[i] <= '0;
        shash_q[i]  <= '0;
      end
    end else begin
      next_nonce_q <= next_nonce_d;
      remaining_q  <= remaining_d;
      target_q     <= target_d;
      hit_count_q  <= hit_count_d;
      done_q       <= done_d;
      eng_start_q  <= eng_start_d;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_q[i]   <= slot_d[i];
        snonce_q[i] <= snonce_d[i];
        shash_q[i]  <= shash_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENGINES; i++) eng_nonce[32*i +: 32] = snonce_q[i];
    eng_start   = eng_start_q;
    done        = done_q;
    hit_count   = hit_count_q;
    found_valid = hit_any;
    found_nonce = hit_any ? snonce_q[hit_idx] : 32'd0;
    found_hash  = hit_any ? shash_q[hit_idx] : 32'd0;
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - scoreboard bench for nonce_scheduler with a fixed-latency engine model
module tb_nonce_scheduler;
  localparam int N   = 4;
  localparam int LAT = 8;

  logic            clk, reset_n, start, abort, found_ready;
  logic [31:0]     nonce_base, nonce_count, target;
  logic [N-1:0]    eng_start, eng_done;
  logic [32*N-1:0] eng_nonce, eng_hout;
  logic            found_valid, busy, done;
  logic [31:0]     found_nonce, found_hash;
  logic [15:0]     hit_count;

  nonce_scheduler #(.NUM_ENGINES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .nonce_base(nonce_base), .nonce_count(nonce_count), .target(target),
    .eng_start(eng_start), .eng_nonce(eng_nonce), .eng_done(eng_done), .eng_hout(eng_hout),
    .found_valid(found_valid), .found_nonce(found_nonce), .found_hash(found_hash),
    .found_ready(found_ready), .busy(busy), .done(done), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_nonce_q[$];
  logic [63:0] exp_hit_q[$];
  int start_pulses, hits_seen, first_start_cyc, last_start_cyc;
  int cyc = 0;
  int cnt[N];
  logic [31:0] lat_nonce[N];
  logic        hout_is_nonce = 1'b0;
  logic [31:0] cur_target = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor and engine model share one negedge process so their ordering is fixed.
  initial begin
    eng_done = '0;
    eng_hout = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        eng_done = '0;
      end else begin
        if (eng_start != '0) check("start_onehot", $countones(eng_start), 1);
        for (int i = 0; i < N; i++) begin
          if (eng_start[i]) begin
            logic have;
            start_pulses++;
            if (first_start_cyc < 0) first_start_cyc = cyc;
            last_start_cyc = cyc;
            have = (exp_nonce_q.size() != 0);
            check("start_expected", have, 1);
            if (have) check("eng_nonce", eng_nonce[32*i +: 32], exp_nonce_q.pop_front());
          end
        end
        if (found_valid && found_ready) begin
          logic have;
          logic [63:0] e;
          hits_seen++;
          have = (exp_hit_q.size() != 0);
          check("hit_expected", have, 1);
          if (have) begin
            e = exp_hit_q.pop_front();
            check("found_nonce", found_nonce, e[63:32]);
            check("found_hash", found_hash, e[31:0]);
          end
        end
        eng_done = '0;
        for (int i = 0; i < N; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              logic [31:0] h;
              h = hout_is_nonce ? lat_nonce[i] : 32'hFFFF_FFFF;
              eng_hout[32*i +: 32] = h;
              eng_done[i] = 1'b1;
              if (h < cur_target) exp_hit_q.push_back({lat_nonce[i], h});
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if (eng_start[i]) begin
            cnt[i] = LAT;
            lat_nonce[i] = eng_nonce[32*i +: 32];
          end
        end
      end
    end
  end

  task automatic run_start(input logic [31:0] base, input logic [31:0] count,
                           input logic [31:0] tgt, input logic mode, input int npush);
    @(posedge clk); #1;
    cur_target = tgt;
    hout_is_nonce = mode;
    start_pulses = 0;
    hits_seen = 0;
    first_start_cyc = -1;
    last_start_cyc = -1;
    for (int k = 0; k < npush; k++) exp_nonce_q.push_back(base + 32'(k));
    nonce_base = base;
    nonce_count = count;
    target = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", seen, 1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; found_ready = 1'b1;
    nonce_base = '0; nonce_count = '0; target = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found_valid", found_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_hit_count", hit_count, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // count of zero: immediate done, nothing issued
    run_start(32'h100, 0, 0, 1'b0, 0);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_hit_count", hit_count, 0);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 0);
    check("t1_busy_after", busy, 0);
    check("t1_starts", start_pulses, 0);

    // all misses, four back-to-back dispatches
    run_start(32'h10, 4, 0, 1'b0, 4);
    check("t2_busy", busy, 1);
    wait_done(100);
    check("t2_busy_end", busy, 0);
    check("t2_starts", start_pulses, 4);
    check("t2_consecutive", last_start_cyc - first_start_cyc, 3);
    check("t2_hits", hits_seen, 0);
    check("t2_hit_count", hit_count, 0);
    @(posedge clk); #1;
    check("t2_done_pulse", done, 0);

    // hout = nonce, target 3: hits 0,1,2 only
    run_start(32'h0, 10, 3, 1'b1, 10);
    wait_done(200);
    check("t3_starts", start_pulses, 10);
    check("t3_hits", hits_seen, 3);
    check("t3_hit_count", hit_count, 3);
    check("t3_hit_q_empty", exp_hit_q.size(), 0);
    check("t3_nonce_q_empty", exp_nonce_q.size(), 0);

    // backpressure: all slots fill with hits and issue stalls
    found_ready = 1'b0;
    run_start(32'h0, 8, 32'hFFFF_FFFF, 1'b1, 8);
    for (int k = 0; k < 50 && start_pulses < 4; k++) begin
      @(posedge clk); #1;
    end
    repeat (20) @(posedge clk);
    #1;
    check("t4_stall_starts", start_pulses, 4);
    check("t4_stall_busy", busy, 1);
    check("t4_stall_valid", found_valid, 1);
    check("t4_stall_lowest", found_nonce, 0);
    check("t4_stall_hit_count", hit_count, 0);
    found_ready = 1'b1;
    wait_done(300);
    check("t4_starts", start_pulses, 8);
    check("t4_hits", hits_seen, 8);
    check("t4_hit_count", hit_count, 8);
    check("t4_hit_q_empty", exp_hit_q.size(), 0);

    // nonce wrap at 2^32
    run_start(32'hFFFF_FFFE, 3, 0, 1'b0, 3);
    wait_done(100);
    check("t5_starts", start_pulses, 3);
    check("t5_nonce_q_empty", exp_nonce_q.size(), 0);

    // abort after the second dispatch
    run_start(32'h1000, 100, 0, 1'b0, 2);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (eng_start[1]) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        break;
      end
    end
    wait_done(100);
    check("t6_starts", start_pulses, 2);
    check("t6_nonce_q_empty", exp_nonce_q.size(), 0);
    check("t6_busy_end", busy, 0);

    // asynchronous reset while a hit is pending
    found_ready = 1'b0;
    run_start(32'h0, 8, 32'hFFFF_FFFF, 1'b1, 8);
    for (int k = 0; k < 50 && !found_valid; k++) begin
      @(posedge clk); #1;
    end
    check("t7_hit_pending", found_valid, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_eng_start", eng_start, 0);
    check("t7_rst_eng_nonce_zero", eng_nonce == '0, 1);
    check("t7_rst_found_valid", found_valid, 0);
    check("t7_rst_found_nonce", found_nonce, 0);
    check("t7_rst_found_hash", found_hash, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_hit_count", hit_count, 0);
    exp_nonce_q.delete();
    exp_hit_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    found_ready = 1'b1;
    run_start(32'h5, 1, 0, 1'b0, 1);
    @(posedge clk); #1;
    check("t7_slot0_start", eng_start, 4'b0001);
    check("t7_slot0_nonce", eng_nonce[31:0], 32'h5);
    wait_done(100);
    check("t7_starts", start_pulses, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
